// File: rtl/arbiter4_rr.sv
// arbiter4_rr: four-way round-robin arbiter with a one-hot grant output.
// Ownership is held while the owner keeps its request high. On release it
// hands off directly to the next pending requester in round-robin order.
// Optional forced revoke after 2^HOLD_W grant cycles: define ARBITER4_RR_TIMEOUT_EN.
// Without it the hold counter is absent and tmo is tied low.

// 2-to-4 decoder cell: one-hot of sel when en is high, zero otherwise.
module arbiter4_rr_dec2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] y
);

  // Decode the select into a single set bit, gated by the enable.
  always_comb begin
    y = 4'b0000;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule

module arbiter4_rr #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       tmo
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [1:0] last_q, last_d;
  logic [1:0] pick;
  logic       req_any;
  logic       owner_req;
  logic       new_grant;
  logic       hold_expired;

  // First requester with req high, searching last+1, last+2, last+3, last.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Round-robin candidate and owner status from the current request levels.
  always_comb begin
    pick      = rr_pick(last_q, req);
    req_any   = |req;
    owner_req = req[gnt_id_q];
  end

  // Next-state logic: grant from idle, hold, hand off, revoke or go idle.
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    new_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          new_grant = 1'b1;
        end
      end
      S_GRANT: begin
        if (!owner_req) begin
          // The owner is not requesting, so pick can never land on it.
          if (req_any) begin
            new_grant = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hold_expired) begin
          // Owner still requesting; search order reaches it last, so it is
          // only re-granted when nobody else is waiting.
          new_grant = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (new_grant) begin
      state_d  = S_GRANT;
      gnt_id_d = pick;
      last_d   = pick;
    end
  end

  // State, owner and round-robin pointer registers; pointer starts at 3 so
  // requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_id_q <= 2'd0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
    end
  end

`ifdef ARBITER4_RR_TIMEOUT_EN
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              tmo_q, tmo_d;

  assign hold_expired = (hcnt_q == '1);

  // Hold counter clears on any new grant and counts every grant cycle; the
  // revoke pulse fires on the edge that takes the grant from a holding owner.
  always_comb begin
    hcnt_d = hcnt_q;
    if (new_grant) begin
      hcnt_d = '0;
    end else if (state_q == S_GRANT) begin
      hcnt_d = hcnt_q + 1'b1;
    end
    tmo_d = (state_q == S_GRANT) && owner_req && hold_expired;
  end

  // Hold counter and revoke pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  assign hold_expired = 1'b0;
  assign tmo          = 1'b0;

  // HOLD_W only sizes the hold counter; this empty block keeps it referenced.
  if (HOLD_W == 0) begin : g_no_hold_counter
  end
`endif

  assign busy   = (state_q == S_GRANT);
  assign gnt_id = gnt_id_q;

  arbiter4_rr_dec2to4 u_gnt_dec (
    .sel (gnt_id_q),
    .en  (busy),
    .y   (gnt)
  );

endmodule

// File: tb/tb_arbiter4_rr.sv
// Directed testbench for arbiter4_rr. Inputs change and outputs are sampled
// on the falling clock edge. Timeout expectations follow whether
// ARBITER4_RR_TIMEOUT_EN is defined for the build (HOLD_W = 2 here).
module tb_arbiter4_rr;

  localparam int unsigned TB_HOLD_W = 2;
`ifdef ARBITER4_RR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       tmo;

  int total;
  int bad;

  arbiter4_rr #(.HOLD_W(TB_HOLD_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .tmo    (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || tmo !== 1'b0 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_init: gnt=%b busy=%b tmo=%b id=%0d want 0000/0/0/0", gnt, busy, tmo, gnt_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_grant: gnt=%b busy=%b want 0100/1", gnt, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || tmo !== 1'b0 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_async: gnt=%b busy=%b tmo=%b id=%0d want 0000/0/0/0", gnt, busy, tmo, gnt_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_prio: gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) begin
        total++;
        if (gnt !== exp_gnt || busy !== 1'b1) begin
          bad++;
          $display("FAIL rr_order k=%0d c=%0d: gnt=%b busy=%b want %b/1", k, c, gnt, busy, exp_gnt);
        end
        if (c == 2) req = 4'b1111 & ~exp_gnt;
        @(negedge clk);
      end
      req = (k == 4) ? 4'b0000 : 4'b1111;
    end
    $display("test_round_robin done");
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL wrap_setup: gnt=%b want 0100", gnt);
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL wrap_idle: busy=%b gnt=%b want 0/0000", busy, gnt);
    end
    req = 4'b0011;
    @(negedge clk);
    total++;
    if (gnt_id !== 2'd0 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_pick0: id=%0d gnt=%b want 0/0001", gnt_id, gnt);
    end
    req = 4'b0010;
    @(negedge clk);
    total++;
    if (gnt_id !== 2'd1 || gnt !== 4'b0010 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wrap_pick1: id=%0d gnt=%b busy=%b want 1/0010/1", gnt_id, gnt, busy);
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_release: busy=%b want 0", busy);
    end
    $display("test_wrap_skip done");
  endtask

  task automatic test_hold_release();
    do_reset();
    req = 4'b0100;
    #1;
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL hold_no_comb_path: gnt=%b want 0000", gnt);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold_cycle %0d: gnt=%b busy=%b want 0100/1", i, gnt, busy);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL hold_drop: busy=%b gnt=%b want 0/0000", busy, gnt);
    end
    $display("test_hold_release done");
  endtask

  // req=0011 held: with forced revoke, owners alternate every 4 cycles with a
  // tmo pulse on each hand-off; without it requester 0 keeps the grant.
  task automatic test_timeout();
    logic [3:0] exp_gnt;
    logic       exp_tmo;
    do_reset();
    req = 4'b0011;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      exp_gnt = (TMO_EN && (((n - 1) / 4) % 2 == 1)) ? 4'b0010 : 4'b0001;
      exp_tmo = TMO_EN && (n > 1) && ((n - 1) % 4 == 0);
      total++;
      if (gnt !== exp_gnt || tmo !== exp_tmo) begin
        bad++;
        $display("FAIL timeout_alt n=%0d: gnt=%b tmo=%b want %b/%b", n, gnt, tmo, exp_gnt, exp_tmo);
      end
    end
    $display("test_timeout done");
  endtask

  // Single requester held: grant never moves; tmo pulses every 4 cycles only
  // when forced revoke is built in.
  task automatic test_timeout_alone();
    logic exp_tmo;
    do_reset();
    req = 4'b1000;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      exp_tmo = TMO_EN && (n > 1) && ((n - 1) % 4 == 0);
      total++;
      if (gnt !== 4'b1000 || busy !== 1'b1 || tmo !== exp_tmo) begin
        bad++;
        $display("FAIL timeout_alone n=%0d: gnt=%b busy=%b tmo=%b want 1000/1/%b", n, gnt, busy, tmo, exp_tmo);
      end
    end
    req = 4'b0000;
    $display("test_timeout_alone done");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_hold_release();
    test_timeout();
    test_timeout_alone();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
